// File: rtl/rock_pkg.sv
// rock_pkg: shared state encoding for the rock sequencer
package rock_pkg;
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETTLE  = 3'd1,
    ROCK    = 3'd2,
    EVAL    = 3'd3,
    BACKOFF = 3'd4,
    FAULT   = 3'd5
  } state_t;
endpackage

// File: rtl/rock_timer.sv
// rock_timer: loadable down-counter that parks at zero
module rock_timer #(
  parameter int TMR_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [TMR_W-1:0] value,
  output logic             zero
);
  logic [TMR_W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = load ? value : (cnt_q != '0) ? cnt_q - TMR_W'(1) : cnt_q;
  always_ff @(posedge clk) begin
    if (!reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
  assign zero = (cnt_q == '0);
endmodule

// File: rtl/rock_sequencer.sv
// rock_sequencer: settle/rock/evaluate loop with stress-driven level and error backoff/fault
module rock_sequencer
  import rock_pkg::*;
#(
  parameter int LVL_W      = 3,
  parameter int TMR_W      = 8,
  parameter int SETTLE_CYC = 4,
  parameter int DWELL_CYC  = 16,
  parameter int MAX_ERR    = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             stress,
  input  logic             pf_error,
  output logic             flow,
  output logic [LVL_W-1:0] level,
  output logic             level_upd,
  output logic [2:0]       state,
  output logic             busy,
  output logic             fault
);
  localparam int ERR_W = $clog2(MAX_ERR + 1);
  localparam logic [LVL_W-1:0] LVL_MAX   = '1;
  localparam logic [TMR_W-1:0] SETTLE_LD = TMR_W'(SETTLE_CYC - 1);
  localparam logic [TMR_W-1:0] DWELL_LD  = TMR_W'(DWELL_CYC - 1);
  localparam logic [ERR_W-1:0] MAX_E     = ERR_W'(MAX_ERR);
  state_t state_q, state_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
  logic err_seen_q, err_seen_d, level_upd_q, level_upd_d;
  logic tmr_load, tmr_zero;
  logic [TMR_W-1:0] tmr_val;
  rock_timer #(.TMR_W(TMR_W)) u_timer (
    .clk(clk), .reset(reset), .load(tmr_load), .value(tmr_val), .zero(tmr_zero)
  );
  always_comb begin
    state_d    = state_q;
    level_d    = level_q;
    err_cnt_d  = err_cnt_q;
    err_seen_d = err_seen_q;
    tmr_load   = 1'b0;
    tmr_val    = SETTLE_LD;
    case (state_q)
      IDLE: if (enable) begin
        state_d  = SETTLE;
        tmr_load = 1'b1;
      end
      SETTLE: if (tmr_zero) begin
        state_d    = ROCK;
        tmr_load   = 1'b1;
        tmr_val    = DWELL_LD;
        err_seen_d = 1'b0;
      end
      ROCK: begin
        err_seen_d = err_seen_q | pf_error;
        if (tmr_zero) state_d = EVAL;
      end
      EVAL: begin
        tmr_load = 1'b1;
        if (err_seen_q) begin
          err_cnt_d = (err_cnt_q == MAX_E) ? err_cnt_q : err_cnt_q + ERR_W'(1);
          state_d   = BACKOFF;
        end else begin
          err_cnt_d = '0;
          if (stress) level_d = (level_q == LVL_MAX) ? level_q : level_q + LVL_W'(1);
          else if (level_q != '0) level_d = level_q - LVL_W'(1);
          state_d = (!stress && level_q == '0) ? IDLE : SETTLE;
        end
      end
      BACKOFF: if (tmr_zero) begin
        state_d  = (err_cnt_q == MAX_E) ? FAULT : SETTLE;
        tmr_load = 1'b1;
      end
      FAULT: if (!enable) begin
        state_d   = IDLE;
        err_cnt_d = '0;
      end
      default: state_d = IDLE;
    endcase
    // losing enable mid-sequence abandons the burst but keeps level and error history
    if (!enable && state_q inside {SETTLE, ROCK, EVAL, BACKOFF}) begin
      state_d    = IDLE;
      level_d    = level_q;
      err_cnt_d  = err_cnt_q;
      err_seen_d = 1'b0;
      tmr_load   = 1'b0;
    end
    level_upd_d = (level_d != level_q);
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      level_q     <= '0;
      err_cnt_q   <= '0;
      err_seen_q  <= 1'b0;
      level_upd_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      level_q     <= level_d;
      err_cnt_q   <= err_cnt_d;
      err_seen_q  <= err_seen_d;
      level_upd_q <= level_upd_d;
    end
  end
  assign flow      = (state_q == ROCK);
  assign level     = level_q;
  assign level_upd = level_upd_q;
  assign state     = state_q;
  assign busy      = (state_q != IDLE) && (state_q != FAULT);
  assign fault     = (state_q == FAULT);
endmodule
